// File: rtl/pipe_ctrl_stage_pkg.sv
// Shared definitions for the control pipeline: bundle widths, field indices, PC-select codes.
// No logic; imported by the interface, hazard unit and stage top.
// Bundle layouts: EX {RegDst, ALUOp[1:0], ALUSrc}, MEM {MemRead, MemWrite, Branch}, WB {RegWrite, MemtoReg}.
package pipe_ctrl_pkg;

  localparam int EX_W  = 4;
  localparam int MEM_W = 3;
  localparam int WB_W  = 2;

  localparam int REGDST   = 3;
  localparam int ALUSRC   = 0;
  localparam int MEMREAD  = 2;
  localparam int MEMWRITE = 1;
  localparam int BRANCH   = 0;
  localparam int REGWRITE = 1;
  localparam int MEMTOREG = 0;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_JR     = 2'b11
  } pc_src_e;

  // One decoded control word as it sits in the ID/EX register.
  typedef struct packed {
    logic [EX_W-1:0]  ex;
    logic [MEM_W-1:0] mem;
    logic [WB_W-1:0]  wb;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_stage_if.sv
// Bus between the decoder/datapath and the control pipeline stage.
// No storage; master = decoder/datapath side, slave = pipe_ctrl_stage.
// PC/IF-ID hold and flush travel slave -> master in the same cycle.
interface pipe_ctrl_stage_if #(
  parameter int REG_W = 5
);
  import pipe_ctrl_pkg::*;

  logic              id_valid;
  logic [EX_W-1:0]   id_ex;
  logic [MEM_W-1:0]  id_mem;
  logic [WB_W-1:0]   id_wb;
  logic              id_jump;
  logic              id_jr;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic              ex_zero;

  logic [EX_W-1:0]   ex_ctrl;
  logic [MEM_W-1:0]  ex_mem_c;
  logic [WB_W-1:0]   ex_wb_c;
  logic [REG_W-1:0]  ex_rt;
  logic [REG_W-1:0]  ex_dst;
  logic [MEM_W-1:0]  mem_ctrl;
  logic [WB_W-1:0]   mem_wb_c;
  logic [REG_W-1:0]  mem_dst;
  logic [WB_W-1:0]   wb_ctrl;
  logic [REG_W-1:0]  wb_dst;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic [1:0]        pc_src;

  modport master (
    output id_valid, id_ex, id_mem, id_wb, id_jump, id_jr, id_rs, id_rt, id_rd, ex_zero,
    input  ex_ctrl, ex_mem_c, ex_wb_c, ex_rt, ex_dst, mem_ctrl, mem_wb_c, mem_dst,
           wb_ctrl, wb_dst, pc_write, if_id_write, if_id_flush, pc_src
  );

  modport slave (
    input  id_valid, id_ex, id_mem, id_wb, id_jump, id_jr, id_rs, id_rt, id_rd, ex_zero,
    output ex_ctrl, ex_mem_c, ex_wb_c, ex_rt, ex_dst, mem_ctrl, mem_wb_c, mem_dst,
           wb_ctrl, wb_dst, pc_write, if_id_write, if_id_flush, pc_src
  );

endinterface

// File: rtl/pipe_ctrl_stage_hazard.sv
// Load-use stall, branch/jump resolution and PC-select for the ID stage.
// Purely combinational: outputs valid in the same cycle as ID inputs and ID/EX state.
// Priority taken branch > load-use stall > jump; stall drops PC and IF/ID write enables.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ex_memread_i,
  input  logic             ex_branch_i,
  input  logic             ex_jump_i,
  input  logic             ex_zero_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic             id_valid_i,
  input  logic             id_jump_i,
  input  logic             id_jr_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  output logic             stall_o,
  output logic             taken_o,
  output logic             jump_o,
  output logic [1:0]       pc_src_o,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o
);

  logic load_use;

  // Resolve hazards; a taken branch squashes the ID instruction, so it also cancels its stall/jump.
  always_comb begin
    load_use      = ex_memread_i && (ex_rt_i != '0) &&
                    ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
    taken_o       = ex_branch_i & ex_zero_i & ~ex_jump_i;
    stall_o       = load_use & ~taken_o;
    jump_o        = id_valid_i & id_jump_i & ~taken_o & ~stall_o;
    pc_write_o    = ~stall_o;
    if_id_write_o = ~stall_o;
    if_id_flush_o = taken_o | jump_o;
    pc_src_o      = PC_SEQ;
    if (taken_o) begin
      pc_src_o = PC_BRANCH;
    end else if (jump_o) begin
      pc_src_o = id_jr_i ? PC_JR : PC_JUMP;
    end
  end

endmodule

// File: rtl/pipe_ctrl_stage.sv
// Control pipeline ID/EX -> EX/MEM -> MEM/WB with load-use bubbles and branch/jump redirect.
// Latency: ID bundles reach ex_* after 1 edge, mem_* after 2, wb_* after 3; hazard outputs same-cycle.
// No backpressure beyond the 1-cycle load-use hold of PC/IF-ID; PIPE_STATS_EN adds stall/flush counters.
module pipe_ctrl_stage
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_stage_if.slave bus
`ifdef PIPE_STATS_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
`endif
);

  ctrl_t            idex_q, idex_d;
  logic [REG_W-1:0] idex_rt_q, idex_rt_d;
  logic [REG_W-1:0] idex_rd_q, idex_rd_d;
  logic             ex_jump_q, ex_jump_d;
  logic [MEM_W-1:0] exmem_mem_q;
  logic [WB_W-1:0]  exmem_wb_q;
  logic [REG_W-1:0] exmem_dst_q;
  logic [WB_W-1:0]  memwb_wb_q;
  logic [REG_W-1:0] memwb_dst_q;
  logic [REG_W-1:0] ex_dst;
  logic             stall, taken, jump_act, bubble;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .ex_memread_i  (idex_q.mem[MEMREAD]),
    .ex_branch_i   (idex_q.mem[BRANCH]),
    .ex_jump_i     (ex_jump_q),
    .ex_zero_i     (bus.ex_zero),
    .ex_rt_i       (idex_rt_q),
    .id_valid_i    (bus.id_valid),
    .id_jump_i     (bus.id_jump),
    .id_jr_i       (bus.id_jr),
    .id_rs_i       (bus.id_rs),
    .id_rt_i       (bus.id_rt),
    .stall_o       (stall),
    .taken_o       (taken),
    .jump_o        (jump_act),
    .pc_src_o      (bus.pc_src),
    .pc_write_o    (bus.pc_write),
    .if_id_write_o (bus.if_id_write),
    .if_id_flush_o (bus.if_id_flush)
  );

  // ID/EX next state: decoder bundles, or an all-zero bubble when ID must not advance into EX.
  always_comb begin
    bubble    = ~bus.id_valid | stall | taken | jump_act;
    idex_d    = '0;
    idex_rt_d = '0;
    idex_rd_d = '0;
    ex_jump_d = jump_act;
    if (!bubble) begin
      idex_d.ex  = bus.id_ex;
      idex_d.mem = bus.id_mem;
      idex_d.wb  = bus.id_wb;
      idex_rt_d  = bus.id_rt;
      idex_rd_d  = bus.id_rd;
    end
  end

  assign ex_dst = idex_q.ex[REGDST] ? idex_rd_q : idex_rt_q;

  // Stage registers; EX/MEM and MEM/WB always advance, reset squashes every in-flight slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q      <= '0;
      idex_rt_q   <= '0;
      idex_rd_q   <= '0;
      ex_jump_q   <= 1'b0;
      exmem_mem_q <= '0;
      exmem_wb_q  <= '0;
      exmem_dst_q <= '0;
      memwb_wb_q  <= '0;
      memwb_dst_q <= '0;
    end else begin
      idex_q      <= idex_d;
      idex_rt_q   <= idex_rt_d;
      idex_rd_q   <= idex_rd_d;
      ex_jump_q   <= ex_jump_d;
      exmem_mem_q <= idex_q.mem;
      exmem_wb_q  <= idex_q.wb;
      exmem_dst_q <= ex_dst;
      memwb_wb_q  <= exmem_wb_q;
      memwb_dst_q <= exmem_dst_q;
    end
  end

  assign bus.ex_ctrl  = idex_q.ex;
  assign bus.ex_mem_c = idex_q.mem;
  assign bus.ex_wb_c  = idex_q.wb;
  assign bus.ex_rt    = idex_rt_q;
  assign bus.ex_dst   = ex_dst;
  assign bus.mem_ctrl = exmem_mem_q;
  assign bus.mem_wb_c = exmem_wb_q;
  assign bus.mem_dst  = exmem_dst_q;
  assign bus.wb_ctrl  = memwb_wb_q;
  assign bus.wb_dst   = memwb_dst_q;

`ifdef PIPE_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Saturating event counters for stall and IF/ID flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (bus.if_id_flush && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
